// File: rtl/tbre_sweep_sched.sv
// tbre_sweep_sched: shares one TBRE revocation sweep engine between NREQ
// requesters. Each requester owns one range slot. A round-robin arbiter launches
// pending ranges with a single-cycle go strobe, then tracks the engine status
// through start and completion. It reports done/err per requester and counts
// completed sweeps (epoch).
//
// Handshake: a request is accepted on a rising clock edge where
// req_valid_i[i] & req_ready_o[i] are both high. req_ready_o[i] is simply
// "slot i has nothing pending", so only one request per requester can be
// pending. A slot freed at an edge becomes ready for the following cycle.
module tbre_sweep_sched #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int TMO  = 255
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ*AW-1:0]  req_start_i,
    input  logic [NREQ*AW-1:0]  req_end_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic [NREQ-1:0]     done_o,
    output logic [NREQ-1:0]     err_o,
    output logic [AW-1:0]       tbre_start_addr_o,
    output logic [AW-1:0]       tbre_end_addr_o,
    output logic                tbre_go_o,
    input  logic                tbre_stat_i,
    output logic [30:0]         epoch_o,
    output logic                busy_o,
    output logic [1:0]          dbg_state_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LAUNCH     = 2'd1,
        S_WAIT_START = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_pending;
    logic [AW-1:0]   r_slot_start [NREQ];
    logic [AW-1:0]   r_slot_end   [NREQ];
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_tmo_cnt;
    logic [30:0]     r_epoch;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic [AW-1:0]   r_start_addr;
    logic [AW-1:0]   r_end_addr;

    logic [NREQ-1:0] w_accept;
    logic [NREQ-1:0] w_range_ok;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic            w_launch;
    logic            w_tmo_fire;
    logic            w_sweep_done;

    assign w_accept = req_valid_i & ~r_pending;

    // Range sanity per requester: end is inclusive, so end == start is legal.
    always_comb begin
        w_range_ok = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_range_ok[i] = (req_end_i[i*AW +: AW] >= req_start_i[i*AW +: AW]);
        end
    end

    // Round-robin pick: first pending slot at or after rr_ptr, wrapping.
    // Scanning offsets high to low lets the smallest offset win.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r_pending[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_pick  = IW'((int'(r_rr_ptr) + k) % NREQ);
                w_found = 1'b1;
            end
        end
    end

    // Next-state and control strobes for the launch/track FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_tmo_fire   = 1'b0;
        w_sweep_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An externally busy engine holds off any launch.
                if (w_found && !tbre_stat_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tbre_stat_i) begin
                    w_state_nxt = S_RUN;
                end else if (r_tmo_cnt == CW'(TMO)) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // RUN is only entered with stat high, so stat low here is the fall.
                if (!tbre_stat_i) begin
                    w_sweep_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register; reset abandons any in-flight sweep.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant capture: addresses change only on a grant and hold until the next one.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
        end else if (w_launch) begin
            r_grant      <= w_pick;
            r_rr_ptr     <= IW'((int'(w_pick) + 1) % NREQ);
            r_start_addr <= r_slot_start[w_pick];
            r_end_addr   <= r_slot_end[w_pick];
        end
    end

    // Start timeout counter: cleared at launch, counts cycles without stat.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT_START && !tbre_stat_i && !w_tmo_fire) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end

    // Request slots, pending bits, one-cycle done/err pulses and epoch counter.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_pending <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_epoch   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot_start[i] <= '0;
                r_slot_end[i]   <= '0;
            end
        end else begin
            r_done <= '0;
            r_err  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) begin
                    if (w_range_ok[i]) begin
                        r_slot_start[i] <= req_start_i[i*AW +: AW];
                        r_slot_end[i]   <= req_end_i[i*AW +: AW];
                        r_pending[i]    <= 1'b1;
                    end else begin
                        r_err[i] <= 1'b1;
                    end
                end
            end
            // The granted slot is pending, hence not ready, so it cannot
            // collide with an accept in the same cycle.
            if (w_tmo_fire) begin
                r_err[r_grant]     <= 1'b1;
                r_pending[r_grant] <= 1'b0;
            end
            if (w_sweep_done) begin
                r_done[r_grant]    <= 1'b1;
                r_pending[r_grant] <= 1'b0;
                r_epoch            <= r_epoch + 31'd1;
            end
        end
    end

    assign req_ready_o       = ~r_pending;
    assign done_o            = r_done;
    assign err_o             = r_err;
    assign tbre_start_addr_o = r_start_addr;
    assign tbre_end_addr_o   = r_end_addr;
    assign tbre_go_o         = (r_state == S_LAUNCH);
    assign epoch_o           = r_epoch;
    assign busy_o            = (r_state != S_IDLE);
    assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_tbre_sweep_sched.sv
// Bench for tbre_sweep_sched: randomized range batches against a transaction
// level model (round-robin service order, reject/timeout/done outcomes), with
// an engine model driving tbre_stat_i and a monitor popping an expected queue.
module tb_tbre_sweep_sched;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int TMO  = 12;
  localparam int EW   = 2 + 2 + 2 * AW;

  localparam logic [1:0] K_GO   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_REJ  = 2'd2;
  localparam logic [1:0] K_TMO  = 2'd3;

  typedef struct packed {
    logic       silent;
    logic [7:0] dly;
    logic [7:0] len;
  } plan_t;

  logic              pclk_i;
  logic              prst_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ*AW-1:0] req_start_i;
  logic [NREQ*AW-1:0] req_end_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   done_o;
  logic [NREQ-1:0]   err_o;
  logic [AW-1:0]     tbre_start_addr_o;
  logic [AW-1:0]     tbre_end_addr_o;
  logic              tbre_go_o;
  logic              tbre_stat_i;
  logic [30:0]       epoch_o;
  logic              busy_o;
  logic [1:0]        dbg_state_o;

  logic              eng_stat;
  logic              ext_busy;
  assign tbre_stat_i = eng_stat | ext_busy;

  logic [EW-1:0] exp_q[$];
  plan_t         plan_q[$];

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            hs_cyc   = 0;
  int            go_cyc   = 0;
  int            n_go     = 0;
  int            m_rr     = 0;
  logic [30:0]   m_epoch  = '0;
  logic [AW-1:0] last_s   = '0;
  logic [AW-1:0] last_e   = '0;
  logic          prev_go  = 1'b0;

  tbre_sweep_sched #(.NREQ(NREQ), .AW(AW), .TMO(TMO)) dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .req_valid_i       (req_valid_i),
    .req_start_i       (req_start_i),
    .req_end_i         (req_end_i),
    .req_ready_o       (req_ready_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .tbre_start_addr_o (tbre_start_addr_o),
    .tbre_end_addr_o   (tbre_end_addr_o),
    .tbre_go_o         (tbre_go_o),
    .tbre_stat_i       (tbre_stat_i),
    .epoch_o           (epoch_o),
    .busy_o            (busy_o),
    .dbg_state_o       (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  always @(posedge pclk_i) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk(input logic [1:0] k, input int i,
                                       input logic [AW-1:0] s, input logic [AW-1:0] e);
    return {k, 2'(i), s, e};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic sb_pop(input string name, output logic [EW-1:0] ex, output bit ok);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
      ex = '0;
      ok = 1'b0;
    end else begin
      ex = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // ---------------- engine model ----------------
  initial begin
    plan_t p;
    eng_stat = 1'b0;
    forever begin
      @(posedge pclk_i);
      #1;
      if (tbre_go_o && !prst_i) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else p = '{silent: 1'b0, dly: 8'd1, len: 8'd1};
        if (!p.silent) begin
          repeat (p.dly) @(posedge pclk_i);
          #1 eng_stat = 1'b1;
          repeat (p.len) @(posedge pclk_i);
          #1 eng_stat = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] mon_ex;
  logic [EW-1:0] mon_act;
  bit            mon_ok;

  always @(negedge pclk_i) begin
    if (!prst_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (err_o[i]) begin
          sb_pop("err_unexpected", mon_ex, mon_ok);
          if (mon_ok) begin
            mon_act = mk((mon_ex[EW-1 -: 2] == K_TMO) ? K_TMO : K_REJ, i, '0, '0);
            check("err_event", mon_act, mon_ex);
            if (mon_ex[EW-1 -: 2] == K_TMO) begin
              check("tmo_latency", cyc - go_cyc, TMO + 2);
              check("tmo_fsm_idle", busy_o, 1'b0);
              check("tmo_epoch_held", epoch_o, m_epoch);
            end else if (mon_ex[EW-1 -: 2] == K_REJ) begin
              check("rej_latency", cyc, hs_cyc);
              check("rej_ready_kept", req_ready_o[i], 1'b1);
            end
          end
        end
        if (done_o[i]) begin
          check("done_err_exclusive", err_o[i], 1'b0);
          sb_pop("done_unexpected", mon_ex, mon_ok);
          if (mon_ok) begin
            mon_act = mk(K_DONE, i, '0, '0);
            check("done_event", mon_act, mon_ex);
            if (mon_ex[EW-1 -: 2] == K_DONE) m_epoch = m_epoch + 31'd1;
            check("epoch_after_done", epoch_o, m_epoch);
            check("addr_hold_start", tbre_start_addr_o, last_s);
            check("addr_hold_end", tbre_end_addr_o, last_e);
          end
        end
      end
      if (tbre_go_o) begin
        n_go++;
        check("go_single_cycle", prev_go, 1'b0);
        sb_pop("go_unexpected", mon_ex, mon_ok);
        if (mon_ok) begin
          mon_act = mk(K_GO, int'(mon_ex[EW-3 -: 2]), tbre_start_addr_o, tbre_end_addr_o);
          check("go_event", mon_act, mon_ex);
          last_s = mon_ex[2*AW-1 -: AW];
          last_e = mon_ex[AW-1:0];
        end
        go_cyc = cyc;
      end
      prev_go = tbre_go_o;
    end else begin
      prev_go = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Model: rejected ranges surface first (one cycle after the handshake),
  // then valid ranges are served in round-robin order from the model pointer.
  task automatic submit(input logic [NREQ-1:0] mask, input logic [NREQ*AW-1:0] s,
                        input logic [NREQ*AW-1:0] e, input logic [NREQ-1:0] silent,
                        input int dly, input int len);
    logic [NREQ-1:0] left;
    int              g;
    plan_t           p;
    left = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        if (e[i*AW +: AW] < s[i*AW +: AW]) exp_q.push_back(mk(K_REJ, i, '0, '0));
        else left[i] = 1'b1;
      end
    end
    while (left != '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && left[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
      exp_q.push_back(mk(K_GO, g, s[g*AW +: AW], e[g*AW +: AW]));
      exp_q.push_back(mk(silent[g] ? K_TMO : K_DONE, g, '0, '0));
      p.silent = silent[g];
      p.dly    = 8'((dly > 0) ? dly : $urandom_range(1, 4));
      p.len    = 8'((len > 0) ? len : $urandom_range(1, 25));
      plan_q.push_back(p);
      left[g] = 1'b0;
      m_rr    = (g + 1) % NREQ;
    end
    @(posedge pclk_i);
    #1;
    hs_cyc      = cyc + 1;
    req_valid_i = mask;
    req_start_i = s;
    req_end_i   = e;
    @(posedge pclk_i);
    #1;
    req_valid_i = '0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge pclk_i);
      #2;
      if (exp_q.size() == 0 && !busy_o && (&req_ready_o)) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else begin
      $display("FAIL %s: not drained, %0d events outstanding, busy=%0d", name, exp_q.size(), busy_o);
      exp_q.delete();
      plan_q.delete();
    end
    check("epoch_after_batch", epoch_o, m_epoch);
  endtask

  // ---------------- stimulus ----------------
  logic [NREQ*AW-1:0] rs, re;
  logic [NREQ-1:0]    rm, rsil;
  logic [AW-1:0]      st;
  int                 sel;
  bit                 seen;

  initial begin
    prst_i      = 1'b1;
    req_valid_i = '0;
    req_start_i = '0;
    req_end_i   = '0;
    ext_busy    = 1'b0;
    repeat (3) @(posedge pclk_i);
    #1;
    check("rst_go", tbre_go_o, 1'b0);
    check("rst_done", done_o, '0);
    check("rst_err", err_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_epoch", epoch_o, '0);
    check("rst_ready", req_ready_o, {NREQ{1'b1}});
    check("rst_addr", {tbre_start_addr_o, tbre_end_addr_o}, '0);
    check("rst_state", dbg_state_o, 2'd0);
    prst_i = 1'b0;

    // Tie between req0 and req1 right after reset, then again.
    rs = {32'h0, 32'h1000_0000, 32'h0800_0000};
    re = {32'h0, 32'h1000_00FF, 32'h0800_0FFF};
    submit(3'b011, rs, re, 3'b000, 0, 0);
    drain("tie_first");
    submit(3'b011, rs, re, 3'b000, 0, 0);
    drain("tie_second");

    // Directed sweep: stat 3 cycles after go, 20 cycles long.
    rs = {32'h0, 32'h0, 32'h2000_0000};
    re = {32'h0, 32'h0, 32'h2000_0FFF};
    submit(3'b001, rs, re, 3'b000, 3, 20);
    drain("single_sweep");

    // Rejected range on req1.
    rs = {32'h0, 32'h0000_0200, 32'h0};
    re = {32'h0, 32'h0000_0100, 32'h0};
    submit(3'b010, rs, re, 3'b000, 0, 0);
    drain("reject");

    // Engine never starts.
    rs = {32'h0, 32'h0, 32'h4000_0000};
    re = {32'h0, 32'h0, 32'h4000_0040};
    submit(3'b001, rs, re, 3'b001, 0, 0);
    drain("timeout");

    // Engine held busy externally before the request.
    @(posedge pclk_i);
    #1 ext_busy = 1'b1;
    rs = {32'h0, 32'h0, 32'h5000_0000};
    re = {32'h0, 32'h0, 32'h5000_0010};
    sel = n_go;
    submit(3'b001, rs, re, 3'b000, 2, 5);
    repeat (10) @(posedge pclk_i);
    #1;
    check("ext_busy_no_go", n_go - sel, 0);
    check("ext_busy_idle", busy_o, 1'b0);
    ext_busy = 1'b0;
    @(posedge pclk_i);
    #1;
    check("go_after_release", tbre_go_o, 1'b1);
    drain("ext_busy");

    // Randomized batches.
    for (int b = 0; b < 30; b++) begin
      rm   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rsil = '0;
      for (int i = 0; i < NREQ; i++) begin
        st  = $urandom_range(32'h0000_1000, 32'hFFFF_0000);
        sel = $urandom_range(0, 5);
        rs[i*AW +: AW] = st;
        if (sel == 0)      re[i*AW +: AW] = st - AW'($urandom_range(1, 255));
        else if (sel == 1) re[i*AW +: AW] = st;
        else               re[i*AW +: AW] = st + AW'($urandom_range(1, 4095));
        rsil[i] = ($urandom_range(0, 5) == 0);
      end
      submit(rm, rs, re, rsil, 0, 0);
      drain("random_batch");
    end

    // Reset in the middle of a running sweep.
    rs = {32'h0, 32'h0, 32'h6000_0000};
    re = {32'h0, 32'h0, 32'h6000_FFFF};
    submit(3'b001, rs, re, 3'b000, 2, 60);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge pclk_i);
      #2;
      if (dbg_state_o == 2'd3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_run", seen, 1'b1);
    repeat (3) @(posedge pclk_i);
    #3 prst_i = 1'b1;
    #1;
    check("mid_rst_go", tbre_go_o, 1'b0);
    check("mid_rst_done", done_o, '0);
    check("mid_rst_err", err_o, '0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_epoch", epoch_o, '0);
    check("mid_rst_ready", req_ready_o, {NREQ{1'b1}});
    exp_q.delete();
    plan_q.delete();
    m_epoch = '0;
    m_rr    = 0;
    repeat (2) @(posedge pclk_i);
    #1 prst_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge pclk_i);
      #2;
      if (!eng_stat) begin
        seen = 1'b1;
        break;
      end
    end
    check("engine_quiet", seen, 1'b1);

    // After reset the round-robin pointer restarts at req0.
    rs = {32'h0, 32'h7100_0000, 32'h7000_0000};
    re = {32'h0, 32'h7100_0010, 32'h7000_0010};
    submit(3'b011, rs, re, 3'b000, 0, 0);
    drain("post_reset_tie");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
